out_mem_drain: RTL and testbench

- Hardware reader for the OUT_MEM result SRAM that MAC_TOP writes.
- After a matrix job finishes, it reads rows 0..NUM_ROWS-1 of OUT_MEM and streams them out on a valid/ready interface with full backpressure.
- It sits between OUT_MEM and the host/result path, and replaces the bench-side direct peek into SRAM contents.

---
 rtl/out_mem_pkg.sv | 33 +++
 rtl/out_drain_fifo.sv | 65 ++++++
 rtl/out_mem_drain.sv | 165 ++++++++++++++++
 tb/tb_out_mem_drain.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_mem_pkg.sv
// ============================================================================
// Module   : out_mem_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the OUT_MEM drain.
//            State CLEAR exists only when OUT_MEM_DRAIN_CLEAR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package out_mem_pkg;

    localparam int AW    = 4;
    localparam int ENTRY = 16;
    localparam int DW    = 64;
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FLUSH = 3'd2,
`ifdef OUT_MEM_DRAIN_CLEAR_EN
        ST_CLEAR = 3'd3,
`endif
        ST_FIN   = 3'd4
    } state_e;

    // Requests larger than the memory depth drain the whole memory.
    function automatic logic [CW-1:0] sat_rows(input logic [CW-1:0] n);
        return (n > CW'(ENTRY)) ? CW'(ENTRY) : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_drain_fifo.sv
// ============================================================================
// Module   : out_drain_fifo
// Purpose  : Two-entry synchronous FIFO holding read rows plus their last flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module out_drain_fifo
    import out_mem_pkg::*;
#(
    parameter int WIDTH = DW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_idx_q;
    logic             rd_idx_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_idx_q];

    assign do_pop  = pop_i & ~empty_o;
    // When full, the slot being written is the one leaving this cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_idx_q] <= data_i;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (do_pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_mem_drain.sv
// ============================================================================
// Module   : out_mem_drain
// Purpose  : Reads rows 0..NUM_ROWS-1 of OUT_MEM and streams them on a
//            valid/ready port. Define OUT_MEM_DRAIN_CLEAR_EN to zero the
//            whole memory after each completed drain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module out_mem_drain
    import out_mem_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [CW-1:0] NUM_ROWS,
    output logic          BUSY,
    output logic          DONE,
    output logic          EN_O,
    output logic          RW_O,
    output logic [AW-1:0] ADDR_O,
    output logic [DW-1:0] WDATA_O,
    input  logic [DW-1:0] RDATA_O,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_LAST
);

    state_e        state_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] last_row_q;
    logic          busy_q;
    logic          done_q;
    logic          inflight_q;
    logic          last_inflight_q;

    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [DW:0]   fifo_head;
    logic          fifo_push;
    logic          pop;
    logic [2:0]    credit;
    logic          issue;
    logic          issue_last;
    logic [CW-1:0] rows_sat;

    assign rows_sat = sat_rows(NUM_ROWS);

    assign pop = OUT_VALID & OUT_READY;
    // Rows held or in flight, minus the word leaving now; crediting the pop
    // lets a 2-deep buffer sustain one row per cycle without overflowing.
    assign credit     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == ST_READ) && (credit < 3'd2);
    assign issue_last = issue && (rd_ptr_q == last_row_q);

    assign fifo_push  = inflight_q & ~fifo_full;

    out_drain_fifo #(
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (fifo_push),
        .data_i  ({last_inflight_q, RDATA_O}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign OUT_VALID = ~fifo_empty;
    assign OUT_DATA  = fifo_head[DW-1:0];
    assign OUT_LAST  = fifo_head[DW];
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign WDATA_O   = '0;

`ifdef OUT_MEM_DRAIN_CLEAR_EN
    logic [AW-1:0] clr_ptr_q;

    assign RW_O   = (state_q == ST_CLEAR);
    assign EN_O   = issue | RW_O;
    assign ADDR_O = RW_O ? clr_ptr_q : (issue ? rd_ptr_q : '0);
`else
    assign RW_O   = 1'b0;
    assign EN_O   = issue;
    assign ADDR_O = issue ? rd_ptr_q : '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            rd_ptr_q        <= '0;
            last_row_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
`ifdef OUT_MEM_DRAIN_CLEAR_EN
            clr_ptr_q       <= '0;
`endif
        end else begin
            inflight_q      <= issue;
            last_inflight_q <= issue_last;
            done_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (NUM_ROWS == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            last_row_q <= AW'(rows_sat - CW'(1));
                            rd_ptr_q   <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        if (issue_last) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (pop && OUT_LAST) begin
`ifdef OUT_MEM_DRAIN_CLEAR_EN
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
`else
                        state_q   <= ST_FIN;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end
                end
`ifdef OUT_MEM_DRAIN_CLEAR_EN
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + AW'(1);
                    if (clr_ptr_q == AW'(ENTRY - 1)) begin
                        state_q <= ST_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_out_mem_drain.sv
// ============================================================================
// Module   : tb_out_mem_drain
// Purpose  : Self-checking bench for out_mem_drain with an SRAM model and a
//            row-level expectation model (honours OUT_MEM_DRAIN_CLEAR_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_out_mem_drain;

    localparam int          AW    = 4;
    localparam int          ENTRY = 16;
    localparam int          DW    = 64;
    localparam logic [63:0] PAT   = 64'h1111_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_rows = '0;
    logic          busy, done, en, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          preload = 1'b0;

    logic [DW-1:0] mem [ENTRY];
    int            cyc = 0;

    out_mem_drain dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .NUM_ROWS  (num_rows),
        .BUSY      (busy),
        .DONE      (done),
        .EN_O      (en),
        .RW_O      (rw),
        .ADDR_O    (addr),
        .WDATA_O   (wdata),
        .RDATA_O   (rdata),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_LAST  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < ENTRY; k++) mem[k] <= PAT + 64'(k);
        end else if (en) begin
            if (rw) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

    int tests = 0;
    int fails = 0;

    logic [64:0] rx_q [$];
    int          rd_q [$];
    int          wr_q [$];
    int          nxfer, ndone;
    int          start_id, first_en_id, first_valid_id, first_xfer_id, last_xfer_id, done_id;
    bit          prev_stall;
    logic [DW:0] prev_word;
    bit          mem_zero = 1'b0;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete(); rd_q.delete(); wr_q.delete();
        nxfer = 0; ndone = 0; prev_stall = 1'b0; prev_word = '0;
        start_id = -1; first_en_id = -1; first_valid_id = -1;
        first_xfer_id = -1; last_xfer_id = -1; done_id = -1;
    endtask

    // Called at each falling edge: observes what the next rising edge will see.
    task automatic monitor();
        if (start && start_id < 0) start_id = cyc;
        if (prev_stall) begin
            chk("stall_valid", 65'(out_valid), 65'(1));
            chk("stall_word", {out_last, out_data}, prev_word);
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
        if (out_valid && first_valid_id < 0) first_valid_id = cyc;
        if (out_valid && out_ready) begin
            rx_q.push_back({out_last, out_data});
            if (first_xfer_id < 0) first_xfer_id = cyc;
            last_xfer_id = cyc;
            nxfer++;
        end
        if (en && !rw) begin
            rd_q.push_back(int'(addr));
            if (first_en_id < 0) first_en_id = cyc;
            tests++;
            assert (rd_q.size() - nxfer <= 2) else begin
                fails++;
                $error("FAIL read_ahead: observed %0d rows ahead expected <=2", rd_q.size() - nxfer);
            end
        end
        if (en && rw) begin
            wr_q.push_back(int'(addr));
            chk("clear_wdata", 65'(wdata), 65'(0));
            chk("clear_busy", 65'(busy), 65'(1));
        end
        if (done) begin
            ndone++;
            done_id = cyc;
            chk("busy_at_done", 65'(busy), 65'(0));
        end
    endtask

    function automatic bit ready_for(input int mode, input int k);
        bit [3:0] pattern;
        pattern = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pattern[3 - (k % 4)];
            default: return ($urandom % 3) != 0;
        endcase
    endfunction

    task automatic do_preload();
        @(posedge clk); #1; preload = 1'b1;
        @(posedge clk); #1; preload = 1'b0;
        mem_zero = 1'b0;
    endtask

    task automatic run_job(input int n, input int mode, input bit reload);
        int rows, k;
        logic [63:0] expd;
        if (reload) do_preload();
        clear_mon();
        rows = (n > ENTRY) ? ENTRY : n;
        @(posedge clk); #1;
        start = 1'b1; num_rows = (AW+1)'(n); out_ready = ready_for(mode, 0);
        @(negedge clk); monitor();
        k = 1;
        while (ndone == 0 && k < 400) begin
            @(posedge clk); #1;
            start = 1'b0; out_ready = ready_for(mode, k);
            @(negedge clk); monitor();
            k++;
        end
        start = 1'b0;
        chk("done_seen", 65'(ndone), 65'(1));
        chk("word_count", 65'(rx_q.size()), 65'(rows));
        for (int i = 0; i < rows && i < rx_q.size(); i++) begin
            expd = mem_zero ? 64'd0 : PAT + 64'(i);
            chk("word_data", 65'(rx_q[i][63:0]), 65'(expd));
            chk("word_last", 65'(rx_q[i][64]), 65'(i == rows - 1));
        end
        chk("read_count", 65'(rd_q.size()), 65'(rows));
        for (int i = 0; i < rd_q.size(); i++) chk("read_addr", 65'(rd_q[i]), 65'(i));
        if (rows == 0) begin
            chk("zero_done_lat", 65'(done_id - start_id), 65'(1));
            chk("zero_no_valid", 65'(first_valid_id), 65'(-1));
        end else begin
            chk("first_en_lat", 65'(first_en_id - start_id), 65'(1));
            chk("first_valid_lat", 65'(first_valid_id - first_en_id), 65'(2));
`ifdef OUT_MEM_DRAIN_CLEAR_EN
            chk("done_lat", 65'(done_id - last_xfer_id), 65'(1 + ENTRY));
`else
            chk("done_lat", 65'(done_id - last_xfer_id), 65'(1));
`endif
            if (mode == 0) chk("throughput", 65'(last_xfer_id - first_xfer_id), 65'(rows - 1));
        end
`ifdef OUT_MEM_DRAIN_CLEAR_EN
        chk("clear_count", 65'(wr_q.size()), 65'(rows > 0 ? ENTRY : 0));
        for (int i = 0; i < wr_q.size(); i++) chk("clear_addr", 65'(wr_q[i]), 65'(i));
        if (rows > 0) mem_zero = 1'b1;
`else
        chk("no_writes", 65'(wr_q.size()), 65'(0));
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  65'(busy),      65'(0));
        chk({tag, "_done"},  65'(done),      65'(0));
        chk({tag, "_en"},    65'(en),        65'(0));
        chk({tag, "_rw"},    65'(rw),        65'(0));
        chk({tag, "_addr"},  65'(addr),      65'(0));
        chk({tag, "_wdata"}, 65'(wdata),     65'(0));
        chk({tag, "_valid"}, 65'(out_valid), 65'(0));
        chk({tag, "_data"},  65'(out_data),  65'(0));
        chk({tag, "_last"},  65'(out_last),  65'(0));
    endtask

    initial begin
        int k;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        do_preload();

        run_job(4, 0, 1'b1);
        run_job(8, 1, 1'b1);
        run_job(0, 0, 1'b1);
        run_job(31, 0, 1'b1);

        // Abort a job after three words, then start a fresh short one.
        do_preload();
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; num_rows = 5'd8; out_ready = 1'b1;
        @(negedge clk); monitor();
        k = 0;
        while (nxfer < 3 && k < 100) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); monitor();
            k++;
        end
        chk("abort_reached_3", 65'(nxfer), 65'(3));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 65'(done), 65'(0));
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle_done", 65'(done), 65'(0));
            chk("abort_idle_valid", 65'(out_valid), 65'(0));
        end
        run_job(2, 0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 1'b1);
        end

`ifdef OUT_MEM_DRAIN_CLEAR_EN
        run_job(5, 0, 1'b1);
        run_job(5, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
